// File: rtl/stage_trace_buffer.sv
// Timestamps every change of the stage-handshake flag vector into a FIFO; entries appear on trace_vld_o one cycle after capture.
// Reader backpressure via trace_rdy_i; when full, a push is taken only alongside a pop, otherwise it is dropped and counted.
module stage_trace_buffer #(
    parameter int FLAG_W = 8,
    parameter int TS_W   = 24,
    parameter int DEPTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      arm_i,
    input  logic                      clear_i,
    input  logic [FLAG_W-1:0]         stop_mask_i,
    input  logic [FLAG_W-1:0]         flag_i,
    output logic                      trace_vld_o,
    input  logic                      trace_rdy_i,
    output logic [TS_W+FLAG_W-1:0]    trace_data_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic [15:0]               overflow_cnt_o,
    output logic [1:0]                state_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = TS_W + FLAG_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [TS_W-1:0]     ts_q, ts_d;
    logic [FLAG_W-1:0]   flag_prev_q, flag_prev_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [15:0]         ovf_q, ovf_d;
    logic [EW-1:0]       mem_q [DEPTH];

    logic                push_req;
    logic                push_ok;
    logic                pop;
    logic                full;
    logic                stop_hit;
    logic [TS_W-1:0]     ts_inc;
    logic [EW-1:0]       push_dat;

    assign stop_hit = (stop_mask_i != '0) && ((flag_i & stop_mask_i) == stop_mask_i);
    assign ts_inc   = (ts_q == '1) ? ts_q : ts_q + TS_W'(1);
    assign push_dat = {ts_q, flag_i};

    // Session control: clear_i outranks arm_i, which is only honoured from IDLE or DONE.
    always_comb begin
        state_d     = state_q;
        ts_d        = ts_q;
        flag_prev_d = flag_prev_q;
        push_req    = 1'b0;
        if (clear_i) begin
            state_d     = S_IDLE;
            ts_d        = '0;
            flag_prev_d = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm_i) begin
                        state_d = S_ARMED;
                        ts_d    = '0;
                    end
                end
                S_ARMED: begin
                    push_req    = 1'b1;
                    flag_prev_d = flag_i;
                    ts_d        = ts_inc;
                    state_d     = stop_hit ? S_DONE : S_CAPTURE;
                end
                S_CAPTURE: begin
                    ts_d = ts_inc;
                    if (flag_i != flag_prev_q) begin
                        push_req    = 1'b1;
                        flag_prev_d = flag_i;
                    end
                    if (stop_hit) begin
                        state_d = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign full    = (count_q == CW'(DEPTH));
    assign pop     = (count_q != '0) && trace_rdy_i;
    assign push_ok = push_req && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push_ok) - CW'(pop);
            if (push_req && !push_ok && ovf_q != 16'hFFFF) begin
                ovf_d = ovf_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ts_q        <= '0;
            flag_prev_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= '0;
        end else begin
            state_q     <= state_d;
            ts_q        <= ts_d;
            flag_prev_q <= flag_prev_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst_n && !clear_i && push_ok) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    assign trace_vld_o    = (count_q != '0);
    assign trace_data_o   = trace_vld_o ? mem_q[rd_ptr_q] : '0;
    assign count_o        = count_q;
    assign overflow_cnt_o = ovf_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_stage_trace_buffer.sv
// Bench for stage_trace_buffer: directed session scenarios then random traffic, checked against a queue-based model.
module tb_stage_trace_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arm_i = 1'b0;
    logic        clear_i = 1'b0;
    logic [7:0]  stop_mask_i = 8'h00;
    logic [7:0]  flag_i = 8'h00;
    logic        trace_rdy_i = 1'b0;

    logic        vld24, vld4;
    logic [31:0] data24;
    logic [11:0] data4;
    logic [4:0]  cnt24, cnt4;
    logic [15:0] ovf24, ovf4;
    logic [1:0]  st24, st4;

    always #5 clk = ~clk;

    stage_trace_buffer #(.FLAG_W(8), .TS_W(24), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .arm_i(arm_i), .clear_i(clear_i),
        .stop_mask_i(stop_mask_i), .flag_i(flag_i),
        .trace_vld_o(vld24), .trace_rdy_i(trace_rdy_i), .trace_data_o(data24),
        .count_o(cnt24), .overflow_cnt_o(ovf24), .state_o(st24));

    stage_trace_buffer #(.FLAG_W(8), .TS_W(4), .DEPTH(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .arm_i(arm_i), .clear_i(clear_i),
        .stop_mask_i(stop_mask_i), .flag_i(flag_i),
        .trace_vld_o(vld4), .trace_rdy_i(trace_rdy_i), .trace_data_o(data4),
        .count_o(cnt4), .overflow_cnt_o(ovf4), .state_o(st4));

    typedef struct {
        int         ts;
        logic [7:0] fl;
    } ent_t;

    // Reference: session state as 0..3, timestamp as an unbounded cycle count (saturation applied on compare)
    ent_t       q[$];
    int         m_state = 0;
    int         m_ts = 0;
    logic [7:0] m_prev = 8'h00;
    int         m_ovf = 0;

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_step();
        bit   stop;
        bit   pop;
        bit   do_push;
        ent_t e;
        if (!rst_n) begin
            q.delete(); m_state = 0; m_ts = 0; m_prev = 8'h00; m_ovf = 0;
            return;
        end
        pop = (q.size() != 0) && trace_rdy_i;
        if (clear_i) begin
            q.delete(); m_state = 0; m_ts = 0; m_prev = 8'h00; m_ovf = 0;
            return;
        end
        stop = (stop_mask_i != 0) && ((flag_i & stop_mask_i) == stop_mask_i);
        do_push = 0;
        e.ts = m_ts;
        e.fl = flag_i;
        case (m_state)
            1: begin
                do_push = 1; m_prev = flag_i; m_ts++;
                m_state = stop ? 3 : 2;
            end
            2: begin
                if (flag_i != m_prev) begin
                    do_push = 1; m_prev = flag_i;
                end
                m_ts++;
                if (stop) m_state = 3;
            end
            default: begin
                if (arm_i) begin
                    m_state = 1; m_ts = 0;
                end
            end
        endcase
        if (pop) void'(q.pop_front());
        if (do_push) begin
            if (q.size() < 16) q.push_back(e);
            else m_ovf = sat(m_ovf + 1, 65535);
        end
    endtask

    task automatic check_all();
        logic [31:0] e24;
        logic [11:0] e4;
        e24 = '0;
        e4  = '0;
        if (q.size() != 0) begin
            e24 = {24'(q[0].ts), q[0].fl};
            e4  = {4'(sat(q[0].ts, 15)), q[0].fl};
        end
        chk("state",    {62'd0, st24},  64'(m_state));
        chk("count",    {59'd0, cnt24}, 64'(q.size()));
        chk("vld",      {63'd0, vld24}, 64'(q.size() != 0));
        chk("overflow", {48'd0, ovf24}, 64'(m_ovf));
        chk("data",     {32'd0, data24}, {32'd0, e24});
        chk("data_ts4", {52'd0, data4},  {52'd0, e4});
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic run_until_ts(input int t);
        for (int i = 0; i < 200 && m_ts != t; i++) tick();
        chk("ts_reach", 64'(m_ts), 64'(t));
    endtask

    logic [31:0] exp_drain [4];

    initial begin
        // Reset
        rst_n = 1'b0;
        tick();
        chk("rst_state", {62'd0, st24}, 64'd0);
        chk("rst_data", {32'd0, data24}, 64'd0);
        rst_n = 1'b1;

        // Basic session: changes at ts 5, 9, 20; bit 0 is the stop condition
        stop_mask_i = 8'h01;
        flag_i = 8'h00;
        arm_i = 1'b1; tick(); arm_i = 1'b0;
        tick();
        run_until_ts(5);  flag_i = 8'h80; tick();
        run_until_ts(9);  flag_i = 8'hC0; tick();
        run_until_ts(20); flag_i = 8'hC1; tick();
        chk("done_state", {62'd0, st24}, 64'd3);
        chk("done_count", {59'd0, cnt24}, 64'd4);
        exp_drain[0] = {24'd0,  8'h00};
        exp_drain[1] = {24'd5,  8'h80};
        exp_drain[2] = {24'd9,  8'hC0};
        exp_drain[3] = {24'd20, 8'hC1};
        trace_rdy_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_entry", {32'd0, data24}, {32'd0, exp_drain[i]});
            tick();
        end
        chk("drain_empty", {63'd0, vld24}, 64'd0);
        trace_rdy_i = 1'b0;

        // Overflow: baseline plus 19 changes with the reader stalled
        clear_i = 1'b1; tick(); clear_i = 1'b0;
        stop_mask_i = 8'h00;
        flag_i = 8'h00;
        arm_i = 1'b1; tick(); arm_i = 1'b0;
        tick();
        for (int i = 1; i <= 19; i++) begin
            flag_i = 8'(i);
            tick();
        end
        chk("full_count", {59'd0, cnt24}, 64'd16);
        chk("full_ovf", {48'd0, ovf24}, 64'd4);
        chk("full_head", {32'd0, data24}, 64'd0);
        repeat (3) tick();
        chk("stall_head", {32'd0, data24}, 64'd0);

        // Full FIFO, pop and push in the same cycle
        trace_rdy_i = 1'b1;
        flag_i = 8'd100;
        tick();
        chk("pp_count", {59'd0, cnt24}, 64'd16);
        chk("pp_ovf", {48'd0, ovf24}, 64'd4);
        chk("pp_head_flags", {56'd0, data24[7:0]}, 64'h01);
        repeat (11) tick();
        trace_rdy_i = 1'b0;
        chk("five_left", {59'd0, cnt24}, 64'd5);

        // Clear mid-capture
        clear_i = 1'b1; tick(); clear_i = 1'b0;
        chk("clr_count", {59'd0, cnt24}, 64'd0);
        chk("clr_vld", {63'd0, vld24}, 64'd0);
        chk("clr_state", {62'd0, st24}, 64'd0);
        chk("clr_ovf", {48'd0, ovf24}, 64'd0);

        // Re-arm restarts ts; 30 quiet cycles saturate a 4-bit stamp; arm in CAPTURE is ignored
        flag_i = 8'h00;
        arm_i = 1'b1; tick(); arm_i = 1'b0;
        tick();
        chk("rearm_base", {32'd0, data24}, 64'd0);
        for (int i = 0; i < 30; i++) begin
            arm_i = (i == 10);
            tick();
        end
        arm_i = 1'b0;
        flag_i = 8'h55;
        tick();
        trace_rdy_i = 1'b1; tick(); trace_rdy_i = 1'b0;
        chk("sat_ts4", {52'd0, data4}, {52'd0, 4'hF, 8'h55});
        chk("ts24_no_rearm", {32'd0, data24}, {32'd0, 24'd31, 8'h55});

        // Mask 0 never stops; then reset mid-session
        flag_i = 8'hFF;
        repeat (4) tick();
        chk("nostop_state", {62'd0, st24}, 64'd2);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("mrst_state", {62'd0, st24}, 64'd0);
        chk("mrst_count", {59'd0, cnt24}, 64'd0);
        chk("mrst_vld", {63'd0, vld24}, 64'd0);
        chk("mrst_data", {32'd0, data24}, 64'd0);
        chk("mrst_ovf", {48'd0, ovf24}, 64'd0);

        // Random traffic
        flag_i = 8'h00;
        for (int i = 0; i < 600; i++) begin
            arm_i   = ($urandom_range(0, 19) == 0);
            clear_i = ($urandom_range(0, 149) == 0);
            trace_rdy_i = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) flag_i = flag_i | 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 40) == 0) flag_i = 8'($urandom);
            if ($urandom_range(0, 30) == 0)
                stop_mask_i = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
            tick();
        end
        arm_i = 1'b0; clear_i = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
